pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry (main + skid) pipeline register for the EX/MEM
//               boundary with registered in_ready and a saturating stall count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_aluout,
  input  logic [DATA_W-1:0] in_writedata,
  input  logic [REG_W-1:0]  in_writereg,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_aluout,
  output logic [DATA_W-1:0] out_writedata,
  output logic [REG_W-1:0]  out_writereg,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int             c_ENT_W   = 2*DATA_W + REG_W + CTRL_W;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [c_ENT_W-1:0] r_main;
  logic [c_ENT_W-1:0] r_skid;
  logic               r_main_valid;
  logic               r_skid_valid;
  logic               r_in_ready;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic [c_ENT_W-1:0] w_in_ent;
  logic               w_accept;
  logic               w_handoff;
  logic               w_main_valid_nxt;
  logic               w_skid_valid_nxt;
  logic               w_main_ld_in;
  logic               w_main_ld_skid;
  logic               w_skid_ld;

  assign w_in_ent  = {in_aluout, in_writedata, in_writereg, in_ctrl};
  assign w_accept  = in_valid & in_ready;
  assign w_handoff = r_main_valid & out_ready;

  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_ld_in     = 1'b0;
    w_main_ld_skid   = 1'b0;
    w_skid_ld        = 1'b0;
    if (w_handoff) begin
      if (r_skid_valid) begin
        // Skid drains into main; anything accepted now queues behind it.
        w_main_ld_skid   = 1'b1;
        w_skid_ld        = w_accept;
        w_skid_valid_nxt = w_accept;
      end else begin
        w_main_ld_in     = w_accept;
        w_main_valid_nxt = w_accept;
      end
    end else if (!r_main_valid) begin
      w_main_ld_in     = w_accept;
      w_main_valid_nxt = w_accept;
    end else if (w_accept) begin
      w_skid_ld        = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_stall_cnt  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      if (w_main_ld_skid) begin
        r_main <= r_skid;
      end else if (w_main_ld_in) begin
        r_main <= w_in_ent;
      end
      if (w_skid_ld) begin
        r_skid <= w_in_ent;
      end
      if (r_main_valid && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // Reset masks the registered ready so nothing is taken while reset is high.
  assign in_ready      = r_in_ready & ~reset;
  assign out_valid     = r_main_valid;
  assign out_aluout    = r_main[c_ENT_W-1 -: DATA_W];
  assign out_writedata = r_main[REG_W+CTRL_W +: DATA_W];
  assign out_writereg  = r_main[CTRL_W +: REG_W];
  assign out_ctrl      = r_main_valid ? r_main[CTRL_W-1:0] : '0;
  assign stall_cnt     = r_stall_cnt;

endmodule

`default_nettype wire
